tlul_host_arbiter: RTL and testbench

- Two-host to one-device arbiter for the lightweight TileLink (TL-UL, single-beat) A/D channels.
- Sits in front of a device such as the high-width-to-lightweight bridge or a peripheral.
- Shares the device between two hosts with round-robin arbitration and a per-host outstanding-request limit.
- Tags the downstream source with the host index and routes D responses back by that tag.

---
 rtl/tlul_host_arbiter_if.sv | 63 ++++++
 rtl/tlul_host_arbiter.sv | 72 +++++++
 tb/tb_tlul_host_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/tlul_host_arbiter_if.sv
// tlul_host_arbiter_if: two-host TL-UL A/D bundle plus the shared device-side A/D channels
interface tlul_host_arbiter_if #(
  parameter int TL_RS = 4,
  parameter int TL_AW = 28
);
  logic [1:0][2:0]       h_a_opcode;
  logic [1:0][2:0]       h_a_param;
  logic [1:0][3:0]       h_a_size;
  logic [1:0][TL_RS-1:0] h_a_source;
  logic [1:0][TL_AW-1:0] h_a_address;
  logic [1:0][3:0]       h_a_mask;
  logic [1:0][31:0]      h_a_data;
  logic [1:0]            h_a_valid;
  logic [1:0]            h_a_ready;
  logic [1:0][2:0]       h_d_opcode;
  logic [1:0][1:0]       h_d_param;
  logic [1:0][3:0]       h_d_size;
  logic [1:0][TL_RS-1:0] h_d_source;
  logic [1:0]            h_d_denied;
  logic [1:0][31:0]      h_d_data;
  logic [1:0]            h_d_corrupt;
  logic [1:0]            h_d_valid;
  logic [1:0]            h_d_ready;
  logic [2:0]            s_a_opcode;
  logic [2:0]            s_a_param;
  logic [3:0]            s_a_size;
  logic [TL_RS:0]        s_a_source;
  logic [TL_AW-1:0]      s_a_address;
  logic [3:0]            s_a_mask;
  logic [31:0]           s_a_data;
  logic                  s_a_corrupt;
  logic                  s_a_valid;
  logic                  s_a_ready;
  logic [2:0]            s_d_opcode;
  logic [1:0]            s_d_param;
  logic [3:0]            s_d_size;
  logic [TL_RS:0]        s_d_source;
  logic                  s_d_denied;
  logic [31:0]           s_d_data;
  logic                  s_d_corrupt;
  logic                  s_d_valid;
  logic                  s_d_ready;
  modport slave (
    input  h_a_opcode, h_a_param, h_a_size, h_a_source, h_a_address, h_a_mask, h_a_data, h_a_valid,
    output h_a_ready,
    output h_d_opcode, h_d_param, h_d_size, h_d_source, h_d_denied, h_d_data, h_d_corrupt, h_d_valid,
    input  h_d_ready,
    output s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address, s_a_mask, s_a_data, s_a_corrupt, s_a_valid,
    input  s_a_ready,
    input  s_d_opcode, s_d_param, s_d_size, s_d_source, s_d_denied, s_d_data, s_d_corrupt, s_d_valid,
    output s_d_ready
  );
  modport master (
    output h_a_opcode, h_a_param, h_a_size, h_a_source, h_a_address, h_a_mask, h_a_data, h_a_valid,
    input  h_a_ready,
    input  h_d_opcode, h_d_param, h_d_size, h_d_source, h_d_denied, h_d_data, h_d_corrupt, h_d_valid,
    output h_d_ready,
    input  s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address, s_a_mask, s_a_data, s_a_corrupt, s_a_valid,
    output s_a_ready,
    output s_d_opcode, s_d_param, s_d_size, s_d_source, s_d_denied, s_d_data, s_d_corrupt, s_d_valid,
    input  s_d_ready
  );
endinterface

// File: rtl/tlul_host_arbiter.sv
// tlul_host_arbiter: two-host round-robin TL-UL arbiter with per-host outstanding limits
module tlul_host_arbiter #(
  parameter int TL_RS   = 4,
  parameter int TL_AW   = 28,
  parameter int MAX_OUT = 4
) (
  input logic                tilelink_clock_i,
  input logic                tilelink_reset_i,
  tlul_host_arbiter_if.slave bus
);
  logic [1:0][3:0] cnt;
  logic            rr_ptr, load_en, sel, gi;
  logic [1:0]      elig, grant, a_fire, d_fire;
  assign load_en = ~bus.s_a_valid | bus.s_a_ready;
  assign sel     = bus.s_d_source[TL_RS];
  // a host at its outstanding limit is never eligible; rr_ptr only breaks ties
  always_comb begin
    for (int i = 0; i < 2; i++) elig[i] = bus.h_a_valid[i] & (cnt[i] != 4'(MAX_OUT));
    grant[0] = elig[0] & (~elig[1] | ~rr_ptr);
    grant[1] = elig[1] & (~elig[0] | rr_ptr);
    gi       = grant[1];
  end
  assign bus.h_a_ready   = load_en ? grant : 2'b00;
  assign a_fire          = bus.h_a_valid & bus.h_a_ready;
  assign d_fire          = (bus.s_d_valid & bus.s_d_ready) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign bus.h_d_valid   = bus.s_d_valid ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign bus.s_d_ready   = bus.h_d_ready[sel];
  assign bus.h_d_opcode  = {2{bus.s_d_opcode}};
  assign bus.h_d_param   = {2{bus.s_d_param}};
  assign bus.h_d_size    = {2{bus.s_d_size}};
  assign bus.h_d_source  = {2{bus.s_d_source[TL_RS-1:0]}};
  assign bus.h_d_denied  = {2{bus.s_d_denied}};
  assign bus.h_d_data    = {2{bus.s_d_data}};
  assign bus.h_d_corrupt = {2{bus.s_d_corrupt}};
  // single-beat A output stage tagged with the winning host index
  always_ff @(posedge tilelink_clock_i)
    if (tilelink_reset_i) begin
      bus.s_a_valid   <= 1'b0;
      bus.s_a_opcode  <= '0;
      bus.s_a_param   <= '0;
      bus.s_a_size    <= '0;
      bus.s_a_source  <= '0;
      bus.s_a_address <= '0;
      bus.s_a_mask    <= '0;
      bus.s_a_data    <= '0;
      bus.s_a_corrupt <= 1'b0;
      rr_ptr          <= 1'b0;
    end else if (load_en) begin
      bus.s_a_valid <= |grant;
      if (|grant) begin
        bus.s_a_opcode  <= bus.h_a_opcode[gi];
        bus.s_a_param   <= bus.h_a_param[gi];
        bus.s_a_size    <= bus.h_a_size[gi];
        bus.s_a_source  <= {gi, bus.h_a_source[gi]};
        bus.s_a_address <= bus.h_a_address[gi];
        bus.s_a_mask    <= bus.h_a_mask[gi];
        bus.s_a_data    <= bus.h_a_data[gi];
        bus.s_a_corrupt <= 1'b0;
        rr_ptr          <= ~gi;
      end
    end
  // outstanding counters; a stray response at zero leaves the counter at zero
  always_ff @(posedge tilelink_clock_i)
    for (int i = 0; i < 2; i++)
      if (tilelink_reset_i) cnt[i] <= '0;
      else if (a_fire[i] & ~d_fire[i]) cnt[i] <= cnt[i] + 4'd1;
      else if (d_fire[i] & ~a_fire[i] & (cnt[i] != '0)) cnt[i] <= cnt[i] - 4'd1;
  // a response for a host with nothing outstanding means the device broke protocol
  always_ff @(posedge tilelink_clock_i)
    for (int i = 0; i < 2; i++)
      if (!tilelink_reset_i) assert (!(d_fire[i] && cnt[i] == '0));
endmodule

// File: tb/tb_tlul_host_arbiter.sv
// tb_tlul_host_arbiter: directed stimulus checked against a transaction-level arbiter model
module tb_tlul_host_arbiter;
  localparam int TL_RS = 4, TL_AW = 28, MAX_OUT = 4;
  logic clk = 1'b0, rst = 1'b1;
  int n_pass = 0, n_total = 0;
  always #5 clk = ~clk;
  tlul_host_arbiter_if #(.TL_RS(TL_RS), .TL_AW(TL_AW)) bus ();
  tlul_host_arbiter #(.TL_RS(TL_RS), .TL_AW(TL_AW), .MAX_OUT(MAX_OUT)) dut (
    .tilelink_clock_i(clk),
    .tilelink_reset_i(rst),
    .bus(bus)
  );
  bit m_live = 0, m_valid = 0;
  int m_last = 1;
  int m_cnt [2];
  logic [4:0] m_src;
  logic [27:0] m_addr;
  logic [31:0] m_data;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", n, a, e);
  endtask
  function automatic int pick();
    bit e0, e1;
    if (m_valid && !bus.s_a_ready) return -1;
    e0 = bus.h_a_valid[0] && m_cnt[0] < MAX_OUT;
    e1 = bus.h_a_valid[1] && m_cnt[1] < MAX_OUT;
    if (e0 && e1) return 1 - m_last;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction
  always @(posedge clk) begin
    int w, ds;
    bit a, d;
    w = pick();
    ds = int'(bus.s_d_source[4]);
    if (rst) begin
      m_live = 1; m_valid = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        a = (w == i);
        d = bus.s_d_valid && bus.h_d_ready[ds] && ds == i;
        if (a && !d) m_cnt[i]++;
        else if (d && !a && m_cnt[i] > 0) m_cnt[i]--;
      end
      if (!m_valid || bus.s_a_ready) begin
        m_valid = (w >= 0);
        if (w >= 0) begin
          m_src = {w[0], bus.h_a_source[w]};
          m_addr = bus.h_a_address[w];
          m_data = bus.h_a_data[w];
          m_last = w;
        end
      end
    end
  end
  always @(negedge clk) if (m_live) begin
    int w, ds;
    w = pick();
    ds = int'(bus.s_d_source[4]);
    chk("h_a_ready", bus.h_a_ready, w < 0 ? 0 : 1 << w);
    chk("s_a_valid", bus.s_a_valid, m_valid);
    if (m_valid) begin
      chk("s_a_source", bus.s_a_source, m_src);
      chk("s_a_address", bus.s_a_address, m_addr);
      chk("s_a_data", bus.s_a_data, m_data);
    end
    chk("h_d_valid", bus.h_d_valid, bus.s_d_valid ? 1 << ds : 0);
    chk("s_d_ready", bus.s_d_ready, bus.h_d_ready[ds]);
    chk("h_d_source", bus.h_d_source[1 - ds], bus.s_d_source[3:0]);
    chk("h_d_data", bus.h_d_data[ds], bus.s_d_data);
    chk("cnt0", dut.cnt[0], m_cnt[0]);
    chk("cnt1", dut.cnt[1], m_cnt[1]);
    chk("rr_ptr", dut.rr_ptr, 1 - m_last);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic host(input int h, input logic [3:0] s, input logic [27:0] a);
    bus.h_a_source[h] = s;
    bus.h_a_address[h] = a;
    bus.h_a_data[h] = {4'h5, a};
    bus.h_a_opcode[h] = 3'd4;
  endtask
  task automatic d_resp(input logic [4:0] s);
    bus.s_d_valid = 1'b1;
    bus.s_d_source = s;
    step();
    bus.s_d_valid = 1'b0;
  endtask
  initial begin
    bus.h_a_opcode = '0; bus.h_a_param = '0; bus.h_a_size = '0; bus.h_a_source = '0;
    bus.h_a_address = '0; bus.h_a_mask = '1; bus.h_a_data = '0; bus.h_a_valid = '0;
    bus.h_d_ready = 2'b11; bus.s_a_ready = 1'b1;
    bus.s_d_opcode = 3'd1; bus.s_d_param = '0; bus.s_d_size = 4'd2; bus.s_d_source = '0;
    bus.s_d_denied = 1'b0; bus.s_d_data = 32'hcafe_f00d; bus.s_d_corrupt = 1'b0; bus.s_d_valid = 1'b0;
    repeat (2) step();
    chk("rst_s_a_valid", bus.s_a_valid, 0);
    chk("rst_cnt", dut.cnt, 0);
    chk("rst_rr", dut.rr_ptr, 0);
    rst = 1'b0;
    host(0, 4'd1, 28'h40);
    host(1, 4'd2, 28'h80);
    bus.h_a_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("cont_ready", bus.h_a_ready, (k % 2) ? 2'b10 : 2'b01);
      step();
      chk("cont_src_msb", bus.s_a_source[4], k % 2);
      bus.h_a_source[k % 2] = bus.h_a_source[k % 2] + 4'd4;
    end
    bus.h_a_valid = 2'b00;
    chk("cont_cnt", dut.cnt, 8'h22);
    d_resp(5'h01); d_resp(5'h05); d_resp(5'h12); d_resp(5'h16);
    chk("drain_cnt", dut.cnt, 8'h00);
    host(0, 4'd3, 28'h100);
    bus.h_a_valid = 2'b01;
    #1 chk("single_ready", bus.h_a_ready, 2'b01);
    step();
    bus.h_a_valid = 2'b00;
    chk("single_valid", bus.s_a_valid, 1);
    chk("single_src", bus.s_a_source, 5'h03);
    chk("single_addr", bus.s_a_address, 28'h100);
    bus.s_d_valid = 1'b1;
    bus.s_d_source = 5'h03;
    #1 chk("single_dvalid", bus.h_d_valid, 2'b01);
    chk("single_dsrc", bus.h_d_source[0], 4'd3);
    step();
    bus.s_d_valid = 1'b0;
    chk("single_cnt", dut.cnt, 8'h00);
    step();
    host(0, 4'd4, 28'h200);
    bus.h_a_valid = 2'b01;
    bus.s_a_ready = 1'b0;
    step();
    host(0, 4'd5, 28'h204);
    repeat (3) begin
      #1 chk("bp_ready", bus.h_a_ready, 2'b00);
      chk("bp_addr", bus.s_a_address, 28'h200);
      chk("bp_src", bus.s_a_source, 5'h04);
      step();
    end
    bus.s_a_ready = 1'b1;
    #1 chk("bp_release_ready", bus.h_a_ready, 2'b01);
    step();
    bus.h_a_valid = 2'b00;
    chk("bp_next_addr", bus.s_a_address, 28'h204);
    d_resp(5'h04); d_resp(5'h05);
    host(1, 4'd0, 28'h300);
    bus.h_a_valid = 2'b10;
    repeat (4) begin
      step();
      bus.h_a_source[1] = bus.h_a_source[1] + 4'd1;
    end
    chk("lim_cnt1", dut.cnt[1], 4);
    host(0, 4'd6, 28'h400);
    bus.h_a_valid = 2'b11;
    #1 chk("lim_h0_ready", bus.h_a_ready, 2'b01);
    step();
    bus.h_a_valid = 2'b10;
    #1 chk("lim_h1_stall", bus.h_a_ready, 2'b00);
    bus.s_d_valid = 1'b1;
    bus.s_d_source = 5'h10;
    step();
    bus.s_d_valid = 1'b0;
    chk("lim_h1_regrant", bus.h_a_ready, 2'b10);
    step();
    bus.h_a_valid = 2'b00;
    d_resp(5'h11); d_resp(5'h12); d_resp(5'h13); d_resp(5'h14); d_resp(5'h06);
    chk("lim_drain", dut.cnt, 8'h00);
    host(0, 4'd7, 28'h500);
    bus.h_a_valid = 2'b01;
    step();
    host(0, 4'd8, 28'h504);
    step();
    host(0, 4'd9, 28'h508);
    bus.s_d_valid = 1'b1;
    bus.s_d_source = 5'h07;
    step();
    bus.s_d_valid = 1'b0;
    bus.h_a_valid = 2'b00;
    chk("simul_cnt0", dut.cnt[0], 2);
    bus.s_d_valid = 1'b1;
    bus.s_d_source = 5'h15;
    bus.h_d_ready = 2'b01;
    #1 chk("dstall_ready", bus.s_d_ready, 0);
    chk("dstall_valid", bus.h_d_valid, 2'b10);
    step();
    chk("dstall_ready_held", bus.s_d_ready, 0);
    chk("dstall_valid_held", bus.h_d_valid, 2'b10);
    bus.s_d_valid = 1'b0;
    bus.h_d_ready = 2'b11;
    host(1, 4'd1, 28'h600);
    bus.h_a_valid = 2'b10;
    repeat (3) begin
      step();
      bus.h_a_source[1] = bus.h_a_source[1] + 4'd1;
    end
    bus.h_a_valid = 2'b00;
    bus.s_a_ready = 1'b0;
    chk("pre_rst_cnt", dut.cnt, 8'h32);
    chk("pre_rst_valid", bus.s_a_valid, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", bus.s_a_valid, 0);
    chk("mid_rst_cnt", dut.cnt, 8'h00);
    chk("mid_rst_rr", dut.rr_ptr, 0);
    rst = 1'b0;
    bus.s_a_ready = 1'b1;
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
